// File: rtl/row_packer_pkg.sv
// Shared definitions for the row packer: default geometry and FSM encoding.
package row_packer_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int LANES_DEF  = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/row_packer_lane_accumulator.sv
// Lane accumulator: inserts each pushed pixel at the next lane, flags word
// completion (full word or row end) and presents the completed word
// combinationally so the caller can register it in the same cycle.
module lane_accumulator #(
    parameter int PIX_W = 8,
    parameter int LANES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   last,
    input  logic [PIX_W-1:0]       pixel,
    output logic [PIX_W*LANES-1:0] word,
    output logic                   complete
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LW-1:0]          lane;
    logic [PIX_W*LANES-1:0] acc;
    logic [PIX_W*LANES-1:0] merged;

    // Accumulated lanes plus the incoming pixel; lanes above stay zero
    // because acc is cleared whenever a word completes.
    always_comb begin
        merged = acc;
        merged[PIX_W*lane +: PIX_W] = pixel;
    end

    assign word     = merged;
    assign complete = push & ((lane == LW'(LANES - 1)) | last);

    // Accumulator and lane index; clear (abort/restart) wins over a push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            lane <= '0;
        end else if (clear || complete) begin
            acc  <= '0;
            lane <= '0;
        end else if (push) begin
            acc  <= merged;
            lane <= lane + 1'b1;
        end
    end

endmodule

// File: rtl/row_packer.sv
// Row packer: gathers a frame of pixels into LANES-wide BRAM words, one row
// per run of words, and writes them through BRAM port A.
module row_packer
    import row_packer_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [7:0]             row_len,
    input  logic [7:0]             num_rows,
    input  logic [PIX_W-1:0]       pixel_in,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    output logic                   ena,
    output logic                   wea,
    output logic [ADDR_W-1:0]      addra,
    output logic [PIX_W*LANES-1:0] dina,
    output logic                   row_done,
    output logic                   frame_done
);

    state_t state, state_nxt;

    logic [7:0]             rl_q, nr_q, col, row;
    logic [ADDR_W-1:0]      wr_addr;
    logic                   start_ok, xfer, last_col, last_row;
    logic [PIX_W*LANES-1:0] word;
    logic                   complete;

    assign start_ok    = Start & (row_len != 8'd0) & (num_rows != 8'd0);
    assign pixel_ready = (state == RUN);
    assign frame_done  = (state == DONE);
    assign xfer        = pixel_valid & pixel_ready;
    assign last_col    = (col == rl_q - 8'd1);
    assign last_row    = (row == nr_q - 8'd1);
    assign wea         = ena;

    lane_accumulator #(
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (Start),
        .push     (xfer),
        .last     (last_col),
        .pixel    (pixel_in),
        .word     (word),
        .complete (complete)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state; a Start in any busy state restarts or abandons the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN: begin
                if (Start)                          state_nxt = start_ok ? RUN : IDLE;
                else if (xfer && last_col && last_row) state_nxt = DONE;
            end
            DONE:    state_nxt = start_ok ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame geometry capture and column/row counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rl_q <= '0;
            nr_q <= '0;
            col  <= '0;
            row  <= '0;
        end else if (Start) begin
            col <= '0;
            row <= '0;
            if (start_ok) begin
                rl_q <= row_len;
                nr_q <= num_rows;
            end
        end else if (xfer) begin
            if (last_col) begin
                col <= '0;
                row <= row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

    // BRAM write port: a completed word is written the following cycle at
    // the pre-restart address, even if a Start arrives alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ena      <= 1'b0;
            row_done <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            wr_addr  <= '0;
        end else begin
            ena      <= complete;
            row_done <= complete & last_col;
            if (complete) begin
                addra <= wr_addr;
                dina  <= word;
            end
            if (start_ok)      wr_addr <= base_addr;
            else if (complete) wr_addr <= wr_addr + 1'b1;
        end
    end

    logic unused_last_row;
    assign unused_last_row = last_row;

endmodule

// File: tb/tb_row_packer.sv
// Directed bench for row_packer with a scoreboard of expected BRAM writes.
module tb_row_packer;

    logic        clk = 1'b0;
    logic        reset, Start, pixel_valid;
    logic [7:0]  base_addr, row_len, num_rows, pixel_in;
    logic        pixel_ready, ena, wea, row_done, frame_done;
    logic [7:0]  addra;
    logic [63:0] dina;

    typedef struct packed {
        logic [7:0]  addr;
        logic [63:0] data;
        logic        rd;
    } wr_t;

    wr_t sb[$];
    int  tests = 0, fails = 0;
    int  rd_cnt = 0, fd_cnt = 0;

    always #5 clk = ~clk;

    row_packer dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .base_addr   (base_addr),
        .row_len     (row_len),
        .num_rows    (num_rows),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .ena         (ena),
        .wea         (wea),
        .addra       (addra),
        .dina        (dina),
        .row_done    (row_done),
        .frame_done  (frame_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            if (row_done)   rd_cnt++;
            if (frame_done) fd_cnt++;
            if (row_done) check("row_done_without_write", 64'(ena), 64'd1);
            if (ena) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 64'(ena), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("addra", 64'(addra), 64'(e.addr));
                    check("dina", dina, e.data);
                    check("wea", 64'(wea), 64'd1);
                    check("row_done", 64'(row_done), 64'(e.rd));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] rl, input logic [7:0] nr);
        Start = 1'b1; base_addr = b; row_len = rl; num_rows = nr;
        tick();
        Start = 1'b0;
    endtask

    task automatic send(input int n, input logic [7:0] first, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3; g++) begin
                    if ($urandom_range(0, 2) != 0) break;
                    pixel_valid = 1'b0;
                    tick();
                end
            end
            pixel_valid = 1'b1;
            pixel_in    = first + 8'(i);
            tick();
        end
        pixel_valid = 1'b0;
    endtask

    // Reference packing model: LANES=8, PIX_W=8.
    task automatic expect_frame(input logic [7:0] b, input int rl, input int nr, input logic [7:0] first);
        logic [7:0]  a;
        logic [7:0]  p;
        logic [63:0] w;
        int          lane;
        a = b; p = first; w = '0; lane = 0;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < rl; c++) begin
                w[8*lane +: 8] = p;
                p++;
                lane++;
                if (lane == 8 || c == rl - 1) begin
                    sb.push_back(wr_t'{addr: a, data: w, rd: (c == rl - 1)});
                    a++;
                    w    = '0;
                    lane = 0;
                end
            end
        end
    endtask

    task automatic end_scn(input string tag, input int exp_rd, input int exp_fd);
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        repeat (3) tick();
        check({tag, "_drain"}, 64'(sb.size()), 64'd0);
        check({tag, "_row_done_cnt"}, 64'(rd_cnt), 64'(exp_rd));
        check({tag, "_frame_done_cnt"}, 64'(fd_cnt), 64'(exp_fd));
        check({tag, "_idle_ready"}, 64'(pixel_ready), 64'd0);
        rd_cnt = 0;
        fd_cnt = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pixel_ready"}, 64'(pixel_ready), 64'd0);
        check({tag, "_ena"}, 64'(ena), 64'd0);
        check({tag, "_wea"}, 64'(wea), 64'd0);
        check({tag, "_addra"}, 64'(addra), 64'd0);
        check({tag, "_dina"}, dina, 64'd0);
        check({tag, "_row_done"}, 64'(row_done), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
        base_addr = '0; row_len = '0; num_rows = '0;
        tick(); tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();

        // Two full words, one row.
        expect_frame(8'h10, 16, 1, 8'h00);
        do_start(8'h10, 8'd16, 8'd1);
        send(16, 8'h00, 1'b0);
        end_scn("full_rate", 1, 1);

        // Partial row-final words with zero fill.
        expect_frame(8'h00, 10, 2, 8'h01);
        do_start(8'h00, 8'd10, 8'd2);
        send(20, 8'h01, 1'b0);
        end_scn("partial", 2, 1);

        // Same frame without and with valid gaps.
        expect_frame(8'h50, 8, 2, 8'h30);
        do_start(8'h50, 8'd8, 8'd2);
        send(16, 8'h30, 1'b0);
        end_scn("nogap", 2, 1);
        expect_frame(8'h50, 8, 2, 8'h30);
        do_start(8'h50, 8'd8, 8'd2);
        send(16, 8'h30, 1'b1);
        end_scn("gaps", 2, 1);

        // Address wrap.
        expect_frame(8'hFF, 16, 1, 8'hC0);
        do_start(8'hFF, 8'd16, 8'd1);
        send(16, 8'hC0, 1'b0);
        end_scn("wrap", 1, 1);

        // Reset mid-row: no write, outputs cleared, idle afterwards.
        do_start(8'h60, 8'd8, 8'd1);
        send(5, 8'h90, 1'b0);
        reset = 1'b1;
        #1;
        check_zero_outputs("mid_reset");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_reset_idle", 64'(pixel_ready), 64'd0);
        check("post_reset_no_write", 64'(ena), 64'd0);

        // Invalid Starts are ignored.
        do_start(8'h00, 8'd0, 8'd3);
        tick();
        check("start_rowlen0_idle", 64'(pixel_ready), 64'd0);
        do_start(8'h00, 8'd4, 8'd0);
        tick();
        check("start_numrows0_idle", 64'(pixel_ready), 64'd0);
        end_scn("invalid_start", 0, 0);

        // Abort after 3 pixels; partial word must never appear.
        do_start(8'h40, 8'd8, 8'd1);
        send(3, 8'hA0, 1'b0);
        expect_frame(8'h80, 8, 1, 8'hB0);
        do_start(8'h80, 8'd8, 8'd1);
        send(8, 8'hB0, 1'b0);
        end_scn("abort", 1, 1);

        // Start coincident with a completing transfer: old write still issued.
        do_start(8'h20, 8'd8, 8'd1);
        send(7, 8'h60, 1'b0);
        sb.push_back(wr_t'{addr: 8'h20, data: 64'h6766656463626160, rd: 1'b1});
        expect_frame(8'h30, 4, 1, 8'h70);
        pixel_valid = 1'b1; pixel_in = 8'h67;
        Start = 1'b1; base_addr = 8'h30; row_len = 8'd4; num_rows = 8'd1;
        tick();
        Start = 1'b0; pixel_valid = 1'b0;
        send(4, 8'h70, 1'b0);
        end_scn("coincident", 2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
